// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm controller: ring FSM states,
// field-select codes and the time-field wrap limits.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_RING   = 2'b10,
        ST_SNOOZE = 2'b11
    } ring_state_e;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'b00,
        FIELD_SEC  = 2'b01,
        FIELD_MIN  = 2'b10,
        FIELD_HOUR = 2'b11
    } field_e;

    localparam int MAX_HOUR   = 23;
    localparam int MAX_MINSEC = 59;

    // Wrapping increment; the >= also recovers from any out-of-range value.
    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max_val);
        return (val >= max_val) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// User-facing signal bundle of the alarm controller: keys, tick, current
// time in, stored alarm time and status out.
interface alarm_controller_if;
    import alarm_pkg::*;

    logic       tick_1hz;
    logic       edit_en;
    logic       left_key;
    logic       right_key;
    logic       up_key;
    logic       snooze_key;
    logic       stop_key;
    logic       alarm_en;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [5:0] alarm_sec;
    field_e     selection;
    logic       ringing;
    logic       snoozed;

    modport slave (
        input  tick_1hz, edit_en, left_key, right_key, up_key,
               snooze_key, stop_key, alarm_en, cur_hour, cur_min, cur_sec,
        output alarm_hour, alarm_min, alarm_sec, selection, ringing, snoozed
    );

    modport master (
        output tick_1hz, edit_en, left_key, right_key, up_key,
               snooze_key, stop_key, alarm_en, cur_hour, cur_min, cur_sec,
        input  alarm_hour, alarm_min, alarm_sec, selection, ringing, snoozed
    );

endinterface

// File: rtl/alarm_field_select.sv
// Tracks which alarm field (sec/min/hour) is being edited; left moves toward
// hour, right toward sec, both saturate. The field is kept while not editing.
module alarm_field_select
    import alarm_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   edit_en,
    input  logic   left_key,
    input  logic   right_key,
    output field_e selection
);

    field_e field_q;
    field_e field_d;

    // Simultaneous left and right cancel out.
    always_comb begin
        field_d = field_q;
        if (edit_en && (left_key ^ right_key)) begin
            if (left_key) begin
                case (field_q)
                    FIELD_SEC: field_d = FIELD_MIN;
                    default:   field_d = FIELD_HOUR;
                endcase
            end else begin
                case (field_q)
                    FIELD_HOUR: field_d = FIELD_MIN;
                    default:    field_d = FIELD_SEC;
                endcase
            end
        end
    end

    assign selection = edit_en ? field_q : FIELD_NONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            field_q <= FIELD_SEC;
        end else begin
            field_q <= field_d;
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: editable alarm time plus a ring/snooze FSM that
// fires on the rising edge of the current-time == alarm-time match.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic               clk,
    input  logic               reset,
    alarm_controller_if.slave  bus
);

    localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    field_e selection;

    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;

    ring_state_e      state_q, state_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
    logic             match, match_q;
    logic             ringing_q, ringing_d;
    logic             snoozed_q, snoozed_d;

    alarm_field_select u_field_select (
        .clk       (clk),
        .reset     (reset),
        .edit_en   (bus.edit_en),
        .left_key  (bus.left_key),
        .right_key (bus.right_key),
        .selection (selection)
    );

    // selection still shows the pre-move field here, so up+left/right
    // increments the field that was selected before the move.
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (bus.edit_en && bus.up_key) begin
            case (selection)
                FIELD_SEC:  sec_d  = wrap_inc(sec_q, 6'(MAX_MINSEC));
                FIELD_MIN:  min_d  = wrap_inc(min_q, 6'(MAX_MINSEC));
                FIELD_HOUR: hour_d = 5'(wrap_inc({1'b0, hour_q}, 6'(MAX_HOUR)));
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
        end else begin
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
        end
    end

    assign match = (bus.cur_hour == hour_q) && (bus.cur_min == min_q) && (bus.cur_sec == sec_q);

    // Editing or disarming overrides every other transition.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        if (bus.edit_en || !bus.alarm_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match && !match_q) begin
                        state_d    = ST_RING;
                        ring_cnt_d = RING_LOAD;
                    end
                end
                ST_RING: begin
                    if (bus.stop_key) begin
                        state_d = ST_ARMED;
                    end else if (bus.snooze_key) begin
                        state_d   = ST_SNOOZE;
                        snz_cnt_d = SNOOZE_LOAD;
                    end else if (ring_cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else if (bus.tick_1hz) begin
                        ring_cnt_d = ring_cnt_q - CNT_ONE;
                    end
                end
                ST_SNOOZE: begin
                    if (bus.stop_key) begin
                        state_d = ST_ARMED;
                    end else if (snz_cnt_q == '0) begin
                        state_d    = ST_RING;
                        ring_cnt_d = RING_LOAD;
                    end else if (bus.tick_1hz) begin
                        snz_cnt_d = snz_cnt_q - CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        ringing_d = (state_d == ST_RING);
        snoozed_d = (state_d == ST_SNOOZE);
    end

    // match_q resets high so an alarm of 00:00:00 cannot fire straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            match_q    <= 1'b1;
            ringing_q  <= 1'b0;
            snoozed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            match_q    <= match;
            ringing_q  <= ringing_d;
            snoozed_q  <= snoozed_d;
        end
    end

    assign bus.alarm_hour = hour_q;
    assign bus.alarm_min  = min_q;
    assign bus.alarm_sec  = sec_q;
    assign bus.selection  = selection;
    assign bus.ringing    = ringing_q;
    assign bus.snoozed    = snoozed_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: a behavioural model checked every
// cycle plus directed scenarios with literal expected values.
module tb_alarm_controller;

    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_RING   = 2;
    localparam int M_SNOOZE = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alarm_controller_if bus ();

    alarm_controller #(
        .RING_SECS   (60),
        .SNOOZE_SECS (300)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    int m_mode;
    int m_field;
    int m_time [3];
    int m_ring_left;
    int m_snz_left;
    bit m_prev_match;

    task automatic check_output(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int limit_of(input int f);
        return (f == 2) ? 24 : 60;
    endfunction

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_field      = 0;
        m_time[0]    = 0;
        m_time[1]    = 0;
        m_time[2]    = 0;
        m_ring_left  = 0;
        m_snz_left   = 0;
        m_prev_match = 1'b1;
    endtask

    task automatic model_step();
        bit match;
        match = (int'(bus.cur_sec) == m_time[0]) && (int'(bus.cur_min) == m_time[1]) &&
                (int'(bus.cur_hour) == m_time[2]);
        if (bus.edit_en || !bus.alarm_en) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ARMED;
        end else if (m_mode == M_ARMED) begin
            if (match && !m_prev_match) begin
                m_mode      = M_RING;
                m_ring_left = 60;
            end
        end else if (m_mode == M_RING) begin
            if (bus.stop_key) m_mode = M_ARMED;
            else if (bus.snooze_key) begin
                m_mode     = M_SNOOZE;
                m_snz_left = 300;
            end else if (m_ring_left == 0) m_mode = M_ARMED;
            else if (bus.tick_1hz) m_ring_left--;
        end else begin
            if (bus.stop_key) m_mode = M_ARMED;
            else if (m_snz_left == 0) begin
                m_mode      = M_RING;
                m_ring_left = 60;
            end else if (bus.tick_1hz) m_snz_left--;
        end
        if (bus.edit_en) begin
            if (bus.up_key) m_time[m_field] = (m_time[m_field] + 1) % limit_of(m_field);
            if (bus.left_key && !bus.right_key && m_field < 2) m_field++;
            if (bus.right_key && !bus.left_key && m_field > 0) m_field--;
        end
        m_prev_match = match;
    endtask

    task automatic compare_model();
        check_output("model_selection", int'(bus.selection), bus.edit_en ? m_field + 1 : 0);
        check_output("model_ringing", int'(bus.ringing), (m_mode == M_RING) ? 1 : 0);
        check_output("model_snoozed", int'(bus.snoozed), (m_mode == M_SNOOZE) ? 1 : 0);
        check_output("model_alarm_sec", int'(bus.alarm_sec), m_time[0]);
        check_output("model_alarm_min", int'(bus.alarm_min), m_time[1]);
        check_output("model_alarm_hour", int'(bus.alarm_hour), m_time[2]);
    endtask

    // Model advances on every edge the DUT sees; outputs are compared 2ns later.
    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
        #2;
        if (chk_en) compare_model();
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit l, input bit r, input bit u, input bit s, input bit st);
        bus.left_key   = l;
        bus.right_key  = r;
        bus.up_key     = u;
        bus.snooze_key = s;
        bus.stop_key   = st;
        @(negedge clk);
        bus.left_key   = 1'b0;
        bus.right_key  = 1'b0;
        bus.up_key     = 1'b0;
        bus.snooze_key = 1'b0;
        bus.stop_key   = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            bus.tick_1hz = 1'b1;
            @(negedge clk);
            bus.tick_1hz = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus.cur_hour = 5'(h);
        bus.cur_min  = 6'(m);
        bus.cur_sec  = 6'(s);
    endtask

    task automatic retrigger();
        set_cur(6, 30, 1);
        idle(2);
        set_cur(6, 30, 0);
        idle(1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.tick_1hz   = 1'b0;
        bus.edit_en    = 1'b0;
        bus.left_key   = 1'b0;
        bus.right_key  = 1'b0;
        bus.up_key     = 1'b0;
        bus.snooze_key = 1'b0;
        bus.stop_key   = 1'b0;
        bus.alarm_en   = 1'b0;
        set_cur(0, 0, 0);

        idle(3);
        check_output("reset_selection", int'(bus.selection), 0);
        check_output("reset_ringing", int'(bus.ringing), 0);
        check_output("reset_alarm_hour", int'(bus.alarm_hour), 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(1);

        bus.edit_en = 1'b1;
        idle(1);
        check_output("edit_sel_sec", int'(bus.selection), 1);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        repeat (5) press(0, 0, 1, 0, 0);
        check_output("edit_sel_hour", int'(bus.selection), 3);
        check_output("edit_hour_5", int'(bus.alarm_hour), 5);
        press(1, 0, 0, 0, 0);
        check_output("left_saturate", int'(bus.selection), 3);
        press(1, 1, 0, 0, 0);
        check_output("left_right_nomove", int'(bus.selection), 3);

        press(0, 1, 0, 0, 0);
        check_output("sel_min", int'(bus.selection), 2);
        repeat (60) press(0, 0, 1, 0, 0);
        check_output("min_wrap", int'(bus.alarm_min), 0);
        check_output("min_wrap_no_carry", int'(bus.alarm_hour), 5);

        press(1, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        check_output("hour_6", int'(bus.alarm_hour), 6);
        press(0, 1, 0, 0, 0);
        repeat (29) press(0, 0, 1, 0, 0);
        press(1, 0, 1, 0, 0);
        check_output("up_left_min", int'(bus.alarm_min), 30);
        check_output("up_left_sel", int'(bus.selection), 3);
        check_output("alarm_sec_0", int'(bus.alarm_sec), 0);

        bus.edit_en = 1'b0;
        idle(1);
        check_output("sel_not_editing", int'(bus.selection), 0);

        set_cur(6, 29, 59);
        bus.alarm_en = 1'b1;
        idle(3);
        check_output("armed_no_ring", int'(bus.ringing), 0);
        set_cur(6, 30, 0);
        idle(1);
        check_output("ring_start", int'(bus.ringing), 1);
        run_ticks(59);
        check_output("ring_59_ticks", int'(bus.ringing), 1);
        run_ticks(1);
        check_output("ring_auto_stop", int'(bus.ringing), 0);
        idle(20);
        check_output("no_rering_hold", int'(bus.ringing), 0);

        retrigger();
        check_output("rering", int'(bus.ringing), 1);
        press(0, 0, 0, 1, 0);
        check_output("snooze_snoozed", int'(bus.snoozed), 1);
        check_output("snooze_ringing", int'(bus.ringing), 0);
        run_ticks(299);
        check_output("snooze_299_ticks", int'(bus.snoozed), 1);
        run_ticks(1);
        check_output("snooze_expire_ring", int'(bus.ringing), 1);
        check_output("snooze_expire_snz", int'(bus.snoozed), 0);
        press(0, 0, 0, 0, 1);
        check_output("stop_ringing", int'(bus.ringing), 0);
        check_output("stop_snoozed", int'(bus.snoozed), 0);
        idle(5);

        retrigger();
        check_output("rering_prio", int'(bus.ringing), 1);
        press(0, 0, 0, 1, 1);
        check_output("stop_over_snooze_r", int'(bus.ringing), 0);
        check_output("stop_over_snooze_s", int'(bus.snoozed), 0);

        retrigger();
        press(0, 0, 0, 1, 0);
        check_output("snooze_before_edit", int'(bus.snoozed), 1);
        bus.edit_en = 1'b1;
        idle(1);
        check_output("edit_aborts_snooze", int'(bus.snoozed), 0);
        bus.edit_en = 1'b0;
        idle(2);

        retrigger();
        check_output("ring_before_reset", int'(bus.ringing), 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_ringing", int'(bus.ringing), 0);
        check_output("async_reset_hour", int'(bus.alarm_hour), 0);
        check_output("async_reset_min", int'(bus.alarm_min), 0);
        @(negedge clk);
        set_cur(0, 0, 0);
        idle(1);
        reset = 1'b0;
        idle(10);
        check_output("no_ring_at_zero", int'(bus.ringing), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter RING_SECS, default 60, the number of tick_1hz pulses a ring lasts before auto-stop.
REQ-002 SHALL have parameter SNOOZE_SECS, default 300, the number of tick_1hz pulses a snooze lasts.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port tick_1hz, input, 1, a one-cycle pulse once per second.
REQ-006 SHALL have port edit_en, input, 1, a level signal that is high while the user edits the alarm time.
REQ-007 SHALL have ports left_key, right_key, up_key, snooze_key and stop_key, each input, 1, each a one-cycle debounced pulse.
REQ-008 SHALL have port alarm_en, input, 1, a level signal; the alarm is armed when high.
REQ-009 SHALL have ports cur_hour, cur_min and cur_sec, inputs of width 5, 6 and 6, carrying the current binary time.
REQ-010 SHALL have ports alarm_hour, alarm_min and alarm_sec, outputs of width 5, 6 and 6, carrying the stored alarm time.
REQ-011 SHALL have port selection, output, 2: 00 not editing, 01 sec, 10 min, 11 hour.
REQ-012 SHALL have port ringing, output, 1, high while in state RING.
REQ-013 SHALL have port snoozed, output, 1, high while in state SNOOZE.

Function
REQ-014 SHALL hold the field select, with values SEC, MIN and HOUR.
- edit_en=1 and left_key: SEC->MIN->HOUR, saturating at HOUR.
- edit_en=1 and right_key: HOUR->MIN->SEC, saturating at SEC.
- left_key and right_key in the same cycle: no move.
REQ-015 SHALL drive selection from the field select while edit_en=1, and drive 00 otherwise; the field select value is retained while not editing.
REQ-016 SHALL, on up_key with edit_en=1, increment the selected field by 1 the next cycle.
- Wrap: sec 59->0, min 59->0, hour 23->0.
- No carry into other fields.
- up_key with left_key or right_key in the same cycle: increment the field selected before the move.
REQ-017 SHALL ignore up_key, left_key and right_key while edit_en=0.
REQ-018 SHALL run a ring FSM with states IDLE, ARMED, RING and SNOOZE.
REQ-019 SHALL force the ring FSM to IDLE on the next edge whenever edit_en=1 or alarm_en=0; these conditions take priority over all other transitions.
REQ-020 SHALL move IDLE->ARMED when alarm_en=1 and edit_en=0.
REQ-021 SHALL compute match = (cur time == alarm time) and register it as match_q.
- ARMED->RING on the edge where match=1 and match_q=0.
- Entry to RING loads the ring counter with RING_SECS.
REQ-022 SHALL apply these RING transitions, in priority order:
- stop_key -> ARMED.
- snooze_key -> SNOOZE, loading the snooze counter with SNOOZE_SECS.
- ring counter at 0 -> ARMED.
The ring counter decrements on each tick_1hz.
REQ-023 SHALL apply these SNOOZE transitions:
- stop_key -> ARMED.
- snooze counter at 0 -> RING, reloading the ring counter.
- snooze_key: ignored.
The snooze counter decrements on each tick_1hz.
REQ-024 SHALL not re-trigger RING from ARMED while match stays high, because edge detection applies.
REQ-025 SHALL assert ringing and snoozed as decodes of the registered state, with 1-cycle latency from the triggering edge.
REQ-026 SHALL size the counters as $clog2(max(RING_SECS, SNOOZE_SECS)+1) bits.

Reset
REQ-027 SHALL set the following on reset, with no dependence on clk:
- state=IDLE, field=SEC.
- alarm_hour/min/sec=0.
- selection=00, ringing=0, snoozed=0.
- match_q=1, so that no ring occurs at time 00:00:00 immediately after reset.
- counters=0.
REQ-028 SHALL abort any ring or snooze immediately when reset is asserted during that ring or snooze.

Structure
REQ-029 SHALL place the ring state enum, field codes (SEC=01, MIN=10, HOUR=11) and limits (MAX_HOUR=23, MAX_MINSEC=59) in a shared package, alarm_pkg.
REQ-030 SHALL implement the field-select FSM of REQ-014 and REQ-015 as sub-module alarm_field_select.
- Inputs: clk, reset, edit_en, left_key, right_key.
- Output: selection.

Verification
REQ-031 Field edit:
- Stimulus: edit_en=1, left_key x2, up_key x5.
- Response: selection=11, alarm_hour=5.
- Then left_key again: selection stays 11.
REQ-032 Wrap:
- Stimulus: select min, up_key x60.
- Response: alarm_min=0 and alarm_hour unchanged.
REQ-033 Ring and auto-stop:
- Stimulus: alarm 06:30:00, alarm_en=1, cur time steps to 06:30:00.
- Response: ringing=1 the next cycle.
- After 60 ticks: ringing=0 and state ARMED, with no re-ring while cur time holds 06:30:00.
REQ-034 Snooze:
- Stimulus: snooze_key during RING.
- Response: snoozed=1 and ringing=0.
- After 300 ticks: ringing=1 again.
- Then stop_key: both outputs 0.
REQ-035 Priority:
- Stimulus: stop_key and snooze_key in the same cycle during RING.
- Response: state ARMED.
- Stimulus: edit_en=1 during SNOOZE.
- Response: state IDLE and snoozed=0 the next cycle.
REQ-036 Reset:
- Stimulus: reset asserted mid-RING with no clk edge.
- Response: ringing=0 and alarm time 00:00:00 immediately.
- Response: no ring when cur time=00:00:00 after reset release.
